// File: rtl/ptp_ts_fifo.sv
// PTP timestamp capture FIFOs (TX/RX) with a coherent 32-bit host read port.
// Word 0 latches the head entry into a per-direction shadow; word 2 pops it.

module ptp_ts_fifo_dir #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 16
) (
    input  logic                HCLK,
    input  logic                HRESETN,
    input  logic                i_cap,
    input  logic [TAG_W-1:0]    i_tag,
    input  logic [79:0]         i_time,
    input  logic                i_ld,
    input  logic                i_pop_req,
    input  logic                i_ovf_clr,
    output logic [TAG_W+79:0]   o_head,
    output logic [5:0]          o_cnt,
    output logic                o_ovf,
    output logic [TAG_W+79:0]   o_shadow,
    output logic                o_shadow_vld
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = TAG_W + 80;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [5:0]    r_cnt;
    logic          r_ovf, r_sv;
    logic [EW-1:0] r_shadow;
    logic          w_full, w_pop, w_push, w_drop;

    // A pop in the same cycle frees the slot the capture lands in
    assign w_full = (r_cnt == 6'(DEPTH));
    assign w_pop  = i_pop_req & r_sv;
    assign w_push = i_cap & (~w_full | w_pop);
    assign w_drop = i_cap & w_full & ~w_pop;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_sv     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 6'd1;
                2'b01:   r_cnt <= r_cnt - 6'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop)         r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
            if (i_ld)           r_sv  <= (r_cnt != 6'd0);
            else if (w_pop)     r_sv  <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push)                   r_mem[r_wr_ptr] <= {i_tag, i_time};
        if (i_ld && r_cnt != 6'd0)    r_shadow        <= r_mem[r_rd_ptr];
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_cnt        = r_cnt;
    assign o_ovf        = r_ovf;
    assign o_shadow     = r_shadow;
    assign o_shadow_vld = r_sv;
endmodule

module ptp_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETN,
    input  logic [79:0]      rtc_time,
    input  logic             cap_tx,
    input  logic [TAG_W-1:0] cap_tx_tag,
    input  logic             cap_rx,
    input  logic [TAG_W-1:0] cap_rx_tag,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             ts_irq
);
    localparam int EW = TAG_W + 80;

    logic                   w_dir;
    logic [1:0]             w_word;
    logic [1:0]             w_cap;
    logic [1:0][TAG_W-1:0]  w_tag;
    logic [1:0][EW-1:0]     w_head, w_sh;
    logic [1:0][5:0]        w_cnt;
    logic [1:0]             w_ovf, w_sv;
    logic [31:0]            w_rd_next;
    logic [31:0]            r_rd_data;
    logic                   r_irq;

    assign w_dir  = rd_addr[2];
    assign w_word = rd_addr[1:0];
    assign w_cap  = {cap_rx, cap_tx};
    assign w_tag  = {cap_rx_tag, cap_tx_tag};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        ptp_ts_fifo_dir #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
            .HCLK         (HCLK),
            .HRESETN      (HRESETN),
            .i_cap        (w_cap[d]),
            .i_tag        (w_tag[d]),
            .i_time       (rtc_time),
            .i_ld         (rd_en && w_word == 2'd0 && w_dir == d[0]),
            .i_pop_req    (rd_en && w_word == 2'd2 && w_dir == d[0]),
            .i_ovf_clr    (rd_en && w_word == 2'd3),
            .o_head       (w_head[d]),
            .o_cnt        (w_cnt[d]),
            .o_ovf        (w_ovf[d]),
            .o_shadow     (w_sh[d]),
            .o_shadow_vld (w_sv[d])
        );
    end

    always_comb begin
        w_rd_next = '0;
        case (w_word)
            2'd0: if (w_cnt[w_dir] != 6'd0) w_rd_next = w_head[w_dir][31:0];
            2'd1: if (w_sv[w_dir])          w_rd_next = w_sh[w_dir][63:32];
            2'd2: if (w_sv[w_dir])          w_rd_next = {w_sh[w_dir][EW-1:80], w_sh[w_dir][79:64]};
            default: w_rd_next = {16'b0, w_ovf[1], w_ovf[0], 2'b0, w_cnt[1], w_cnt[0]};
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_rd_data <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (rd_en) r_rd_data <= w_rd_next;
            r_irq <= (w_cnt[0] != 6'd0) | (w_cnt[1] != 6'd0);
        end
    end

    assign rd_data = r_rd_data;
    assign ts_irq  = r_irq;
endmodule

// File: tb/tb_ptp_ts_fifo.sv
// Directed, table-driven bench for ptp_ts_fifo (DEPTH=4).
module tb_ptp_ts_fifo;
    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic [79:0] rtc_time;
    logic        cap_tx, cap_rx, rd_en;
    logic [15:0] cap_tx_tag, cap_rx_tag;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ts_irq;

    ptp_ts_fifo #(.DEPTH(4), .TAG_W(16)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .rtc_time(rtc_time),
        .cap_tx(cap_tx), .cap_tx_tag(cap_tx_tag),
        .cap_rx(cap_rx), .cap_rx_tag(cap_rx_tag),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ts_irq(ts_irq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic        ctx;
        logic [15:0] ttag;
        logic        crx;
        logic [15:0] rtag;
        logic [79:0] rtc;
        logic        rd;
        logic [2:0]  addr;
        logic        chk_d;
        logic [31:0] ed;
        logic        chk_i;
        logic        ei;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [79:0] rk(int k);
        return {16'hBEE0 | 16'(k), 32'(k), 32'h1000_0000 + 32'(k)};
    endfunction

    function automatic void vec(string n, logic ctx, logic [15:0] tt, logic crx, logic [15:0] rt,
                                logic [79:0] t, logic rd, logic [2:0] a,
                                logic cd, logic [31:0] ed, logic ci, logic ei);
        vec_t v;
        v.name = n; v.ctx = ctx; v.ttag = tt; v.crx = crx; v.rtag = rt; v.rtc = t;
        v.rd = rd; v.addr = a; v.chk_d = cd; v.ed = ed; v.chk_i = ci; v.ei = ei;
        vq.push_back(v);
    endfunction

    function automatic void rdv(string n, logic [2:0] a, logic [31:0] ed);
        vec(n, 0, 0, 0, 0, 0, 1, a, 1, ed, 0, 0);
    endfunction

    function automatic void capt(logic [15:0] tag, logic [79:0] t);
        vec("cap_tx", 1, tag, 0, 0, t, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void capr(logic [15:0] tag, logic [79:0] t);
        vec("cap_rx", 0, 0, 1, tag, t, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", n, act, exp);
    endtask

    task automatic run_queue();
        foreach (vq[i]) begin
            @(negedge HCLK);
            cap_tx = vq[i].ctx; cap_tx_tag = vq[i].ttag;
            cap_rx = vq[i].crx; cap_rx_tag = vq[i].rtag;
            rtc_time = vq[i].rtc; rd_en = vq[i].rd; rd_addr = vq[i].addr;
            @(posedge HCLK);
            #1;
            if (vq[i].chk_d) check($sformatf("%s[%0d].rd_data", vq[i].name, i), rd_data, vq[i].ed);
            if (vq[i].chk_i) check($sformatf("%s[%0d].ts_irq", vq[i].name, i), 32'(ts_irq), 32'(vq[i].ei));
        end
        @(negedge HCLK);
        cap_tx = 0; cap_rx = 0; rd_en = 0;
        vq.delete();
    endtask

    initial begin
        HRESETN = 0; rtc_time = '0; cap_tx = 0; cap_rx = 0;
        cap_tx_tag = '0; cap_rx_tag = '0; rd_en = 0; rd_addr = '0;
        repeat (2) @(negedge HCLK);
        check("reset.rd_data", rd_data, 32'h0);
        check("reset.ts_irq", 32'(ts_irq), 32'h0);
        HRESETN = 1;

        // Basic capture and three-word read
        vec("cap1", 1, 16'h1234, 0, 0, 80'h0000_0000_0005_1234_5678, 0, 0, 0, 0, 1, 0);
        vec("irq_rise", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        rdv("tx_w0", 3'd0, 32'h1234_5678);
        rdv("tx_w1", 3'd1, 32'h0000_0005);
        vec("tx_w2", 0, 0, 0, 0, 0, 1, 3'd2, 1, 32'h1234_0000, 1, 1);
        vec("irq_fall", 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_0000, 1, 0);
        rdv("status0", 3'd3, 32'h0);

        // RX overflow: fifth capture dropped
        for (int k = 1; k <= 5; k++) capr(16'(k), rk(k));
        rdv("ovf_status", 3'd7, 32'h0000_8100);
        rdv("ovf_cleared", 3'd3, 32'h0000_0100);
        for (int k = 1; k <= 4; k++) begin
            rdv("rx_drain_w0", 3'd4, 32'h1000_0000 + 32'(k));
            rdv("rx_drain_w1", 3'd5, 32'(k));
            rdv("rx_drain_w2", 3'd6, {16'(k), 16'hBEE0 | 16'(k)});
        end

        // Simultaneous strobes
        vec("cap_both", 1, 16'h000A, 1, 16'h000B, 80'h0000_0000_0077_0000_0099, 0, 0, 0, 0, 0, 0);
        rdv("both_status", 3'd3, 32'h0000_0041);
        rdv("both_tx_w0", 3'd0, 32'h0000_0099);
        rdv("both_tx_w1", 3'd1, 32'h0000_0077);
        rdv("both_tx_w2", 3'd2, 32'h000A_0000);
        rdv("both_rx_w0", 3'd4, 32'h0000_0099);
        rdv("both_rx_w1", 3'd5, 32'h0000_0077);
        rdv("both_rx_w2", 3'd6, 32'h000B_0000);

        // Shadow coherence, double word-2, empty reads
        capr(16'h00A1, rk(8'h41));
        rdv("coh_w0", 3'd4, 32'h1000_0041);
        capr(16'h00B2, rk(8'h42));
        rdv("coh_w1", 3'd5, 32'h0000_0041);
        rdv("coh_w2", 3'd6, {16'h00A1, 16'hBEE0 | 16'h41});
        rdv("coh_w2_again", 3'd6, 32'h0);
        rdv("coh_status", 3'd3, 32'h0000_0040);
        rdv("b_w0", 3'd4, 32'h1000_0042);
        rdv("b_w2", 3'd6, {16'h00B2, 16'hBEE0 | 16'h42});
        rdv("empty_w0", 3'd4, 32'h0);
        rdv("empty_w2", 3'd6, 32'h0);
        vec("empty_status", 0, 0, 0, 0, 0, 1, 3'd3, 1, 32'h0, 1, 0);

        // TX full with pop and capture in the same cycle
        for (int j = 0; j < 4; j++) capt(16'h10 + 16'(j), rk(8'h20 + j));
        rdv("full_status", 3'd3, 32'h0000_0004);
        rdv("full_w0", 3'd0, 32'h1000_0020);
        rdv("full_w1", 3'd1, 32'h0000_0020);
        vec("full_pop_cap", 1, 16'h14, 0, 0, rk(8'h24), 1, 3'd2, 1, {16'h10, 16'hBEE0 | 16'h20}, 0, 0);
        rdv("full_after", 3'd3, 32'h0000_0004);
        for (int j = 1; j <= 4; j++) begin
            rdv("full_drain_w0", 3'd0, 32'h1000_0020 + 32'(j));
            rdv("full_drain_w2", 3'd2, {16'h10 + 16'(j), 16'hBEE0 | (16'h20 + 16'(j))});
        end
        rdv("full_empty", 3'd3, 32'h0);

        // Queue up entries for the mid-read reset
        for (int j = 0; j < 3; j++) capt(16'h30 + 16'(j), rk(8'h30 + j));
        vec("pre_rst_w0", 0, 0, 0, 0, 0, 1, 3'd0, 1, 32'h1000_0030, 1, 1);
        run_queue();

        HRESETN = 0;
        #1;
        check("rst_mid.rd_data", rd_data, 32'h0);
        check("rst_mid.ts_irq", 32'(ts_irq), 32'h0);
        @(negedge HCLK);
        HRESETN = 1;

        vec("post_rst_status", 0, 0, 0, 0, 0, 1, 3'd3, 1, 32'h0, 1, 0);
        rdv("post_rst_w2", 3'd2, 32'h0);
        rdv("post_rst_w0", 3'd0, 32'h0);
        vec("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
